// File: rtl/inv_clarke_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_clarke_if
// Description : Start/done handshake and data bus for the inverse Clarke
//               transform. The sat flag exists only when
//               INV_CLARKE_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface inv_clarke_if #(
  parameter int D_WIDTH = 18
);
  logic signed [D_WIDTH-1:0] alpha;
  logic signed [D_WIDTH-1:0] beta;
  logic                      start;
  logic signed [D_WIDTH-1:0] a;
  logic signed [D_WIDTH-1:0] b;
  logic signed [D_WIDTH-1:0] c;
  logic                      busy;
  logic                      done;
`ifdef INV_CLARKE_SATURATE_EN
  logic                      sat;

  modport master (output alpha, beta, start, input a, b, c, busy, done, sat);
  modport slave  (input alpha, beta, start, output a, b, c, busy, done, sat);
`else
  modport master (output alpha, beta, start, input a, b, c, busy, done);
  modport slave  (input alpha, beta, start, output a, b, c, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/inv_clarke.sv
`default_nettype none
// ============================================================================
// Module      : inv_clarke
// Description : Inverse Clarke transform (alpha/beta -> a/b/c), signed
//               fixed point with Q_BITS fractional bits. Three-cycle
//               IDLE -> MUL -> ADD sequence behind a start/done handshake.
//               Define INV_CLARKE_SATURATE_EN to clamp b/c instead of
//               wrapping, and to enable the sat output.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_clarke #(
  parameter int D_WIDTH = 18,
  parameter int Q_BITS  = 15
) (
  input  logic        clk,
  input  logic        rstb,
  inv_clarke_if.slave bus
);

  // sqrt(3)/2 scaled by 2^Q_BITS, floored (positive, so truncation == floor)
  localparam int c_k_int = $rtoi(0.86602540378 * (2.0 ** Q_BITS));
  localparam logic signed [D_WIDTH-1:0] c_k = D_WIDTH'(c_k_int);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_accept;
  logic   w_busy;

  logic signed [D_WIDTH-1:0]   r_alpha;
  logic signed [D_WIDTH-1:0]   r_beta;
  logic signed [D_WIDTH-1:0]   r_half;
  logic signed [D_WIDTH-1:0]   r_m;
  logic signed [D_WIDTH-1:0]   r_a;
  logic signed [D_WIDTH-1:0]   r_b;
  logic signed [D_WIDTH-1:0]   r_c;
  logic                        r_done;

  logic signed [2*D_WIDTH-1:0] w_prod;
  logic signed [D_WIDTH-1:0]   w_m;
  logic signed [D_WIDTH+1:0]   w_neg_half;
  logic signed [D_WIDTH+1:0]   w_m_ext;
  logic signed [D_WIDTH+1:0]   w_b_sum;
  logic signed [D_WIDTH+1:0]   w_c_sum;
  logic signed [D_WIDTH-1:0]   w_b_out;
  logic signed [D_WIDTH-1:0]   w_c_out;

  // Full-width product; the arithmetic shift floors toward -inf. |m| never
  // exceeds 2^(D_WIDTH-1) because K < 2^Q_BITS, so D_WIDTH bits suffice.
  assign w_prod     = r_beta * c_k;
  assign w_m        = D_WIDTH'(w_prod >>> Q_BITS);

  // Sums are built two bits wider so the pre-reduction value is exact.
  assign w_neg_half = -((D_WIDTH+2)'(r_half));
  assign w_m_ext    = (D_WIDTH+2)'(r_m);
  assign w_b_sum    = w_neg_half + w_m_ext;
  assign w_c_sum    = w_neg_half - w_m_ext;

`ifdef INV_CLARKE_SATURATE_EN
  localparam logic signed [D_WIDTH+1:0] c_sum_max = {3'b000, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH+1:0] c_sum_min = {3'b111, {(D_WIDTH-1){1'b0}}};
  localparam logic signed [D_WIDTH-1:0] c_out_max = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH-1:0] c_out_min = {1'b1, {(D_WIDTH-1){1'b0}}};

  logic r_sat;
  logic w_sat;

  // Clamp b and c to the representable range and flag any clamp.
  always_comb begin
    w_b_out = D_WIDTH'(w_b_sum);
    w_c_out = D_WIDTH'(w_c_sum);
    w_sat   = 1'b0;
    if (w_b_sum > c_sum_max) begin
      w_b_out = c_out_max;
      w_sat   = 1'b1;
    end else if (w_b_sum < c_sum_min) begin
      w_b_out = c_out_min;
      w_sat   = 1'b1;
    end
    if (w_c_sum > c_sum_max) begin
      w_c_out = c_out_max;
      w_sat   = 1'b1;
    end else if (w_c_sum < c_sum_min) begin
      w_c_out = c_out_min;
      w_sat   = 1'b1;
    end
  end

  assign bus.sat = r_sat;
`else
  // Plain two's-complement wrap on reduction.
  assign w_b_out = D_WIDTH'(w_b_sum);
  assign w_c_out = D_WIDTH'(w_c_sum);
`endif

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; busy covers MUL and ADD, start is only seen in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = S_MUL;
        end
      end
      S_MUL:   w_next_state = S_ADD;
      S_ADD:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: capture inputs, form half/m, then publish a/b/c with done.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_alpha <= '0;
      r_beta  <= '0;
      r_half  <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_done  <= 1'b0;
`ifdef INV_CLARKE_SATURATE_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef INV_CLARKE_SATURATE_EN
      r_sat  <= 1'b0;
`endif
      if (w_accept) begin
        r_alpha <= bus.alpha;
        r_beta  <= bus.beta;
      end
      if (r_state == S_MUL) begin
        r_half <= r_alpha >>> 1;
        r_m    <= w_m;
      end
      if (r_state == S_ADD) begin
        r_a    <= r_alpha;
        r_b    <= w_b_out;
        r_c    <= w_c_out;
        r_done <= 1'b1;
`ifdef INV_CLARKE_SATURATE_EN
        r_sat  <= w_sat;
`endif
      end
    end
  end

  assign bus.a    = r_a;
  assign bus.b    = r_b;
  assign bus.c    = r_c;
  assign bus.done = r_done;
  assign bus.busy = w_busy;

endmodule
`default_nettype wire

// File: doc/inv_clarke.md
Name: inv_clarke

Overview:
- Inverse Clarke transform for the FOC datapath: converts stationary-frame alpha/beta back to three phase quantities a, b, c.
- Feeds the PWM/SVM stage.
- Fixed-point signed Q format with Q_BITS fractional bits, matching the forward Clarke block.
- Multi-cycle FSM with a start/done handshake; one transform in flight at a time.

Parameters:
- D_WIDTH, 18, signed data width of all inputs and outputs.
- Q_BITS, 15, fractional bits. D_WIDTH = Q_BITS + 3.

Ports:
- clk  input  1  clock.
- rstb  input  1  asynchronous active-low reset.
- alpha  input  D_WIDTH  signed alpha component, sampled on an accepted start.
- beta  input  D_WIDTH  signed beta component, sampled on an accepted start.
- start  input  1  request; accepted only when busy=0.
- a  output  D_WIDTH  signed phase a.
- b  output  D_WIDTH  signed phase b.
- c  output  D_WIDTH  signed phase c.
- busy  output  1  high while a transform is in flight.
- done  output  1  one-cycle pulse; a/b/c are valid from this cycle.

Behaviour:
- Reset is rstb, asynchronous, active-low; clock is clk. On reset: a=b=c=0, busy=0, done=0, state=IDLE, internal registers=0.
- Math:
  - a = alpha
  - b = -alpha/2 + K*beta
  - c = -alpha/2 - K*beta
  - K = floor(0.86602540378 * 2^Q_BITS), which is 28377 for the defaults.
- Width rules:
  - half = alpha >>> 1 (arithmetic shift, floor).
  - m = (beta * K) >>> Q_BITS, with a full 2*D_WIDTH signed product and floor rounding.
  - b and c sums are formed in D_WIDTH+2 bits, then reduced to D_WIDTH by truncation (two's-complement wrap) unless the optional feature is enabled.
- States:
  - IDLE: busy=0. On start=1, register alpha and beta, go to MUL.
  - MUL: register half and m, go to ADD.
  - ADD: register a, b, c; done=1 in the next cycle; go to IDLE.
- Latency: start accepted at edge N. Outputs are updated and done=1 after edge N+2. busy=1 after edges N and N+1, and returns to 0 with done.
- Throughput: one transform per 3 cycles. A start high in the done cycle is accepted (state is IDLE), so back-to-back operation is legal.
- start while busy=1 is ignored and not queued. Input changes while busy have no effect on the result in flight.
- done is a single-cycle pulse, including when start is held high continuously. Each accepted start yields exactly one done.
- a/b/c hold their last values between completions; they never show partial results.
- rstb asserted mid-operation: immediate clear, no done for the aborted transform.

Optional Feature:
- Macro: INV_CLARKE_SATURATE_EN.
- Defined: before reduction to D_WIDTH, b and c clamp to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1]. An extra output sat (1 bit, reset 0) pulses with done when either b or c clamped.
- Undefined: plain truncation/wrap, and no sat port.
- a never clamps in either mode.

Test Plan:
- Reset, then alpha=16384, beta=0, start -> after 3 cycles done=1; a=16384, b=-8192, c=-8192; busy=0 in the done cycle.
- alpha=0, beta=32767 -> a=0, b=28376, c=-28376. Then beta=-32768 -> b=-28377, c=28377.
- Hold start=1 for 10 cycles with alpha=-16384, beta=0 -> done pulses at cycles 3, 6, 9 (relative to the first accept), single-cycle each; a=-16384, b=8192, c=8192. The start while busy does not shorten latency.
- alpha=-131072, beta=131071:
  - Without the macro: a=-131072, b=-83101 (wrapped from 179043), c=-47971.
  - With INV_CLARKE_SATURATE_EN: b=131071, c=-47971, sat=1 with done.
- Assert rstb low in state MUL after a start with alpha=16384 -> a=b=c=0, busy=0, no done pulse. A fresh start after release completes normally in 3 cycles.
- Change alpha/beta every cycle while busy -> outputs reflect only the values sampled on the accepting edge.
